// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle divide-by-zero and signed-overflow results.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_rdata,
    input  logic [XLEN-1:0] rs2_rdata,
    input  logic [4:0]      rd_waddr,
    input  logic            flush,
    output logic            hold_o,
    output logic            rd_we_o,
    output logic [4:0]      rd_waddr_o,
    output logic [XLEN-1:0] rd_wdata_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          waddr_q, waddr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;

    logic                sign_a, sign_b, div_zero, div_ovf;
    logic [XLEN-1:0]     abs_a, abs_b, special_res, final_res;
    logic [XLEN:0]       mul_sum, rem_sh, trial;
    logic [XLEN-1:0]     rem_new;
    logic [2*XLEN-1:0]   step_acc, prod_s;

    // Operand decode at issue time: magnitudes plus the one-cycle special cases.
    always_comb begin
        sign_a   = (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM)
                   && rs1_rdata[XLEN-1];
        sign_b   = (op == OP_MULH || op == OP_DIV || op == OP_REM) && rs2_rdata[XLEN-1];
        abs_a    = sign_a ? -rs1_rdata : rs1_rdata;
        abs_b    = sign_b ? -rs2_rdata : rs2_rdata;
        div_zero = op[2] && (rs2_rdata == '0);
        div_ovf  = (op == OP_DIV || op == OP_REM) && (rs1_rdata == MIN_NEG)
                   && (rs2_rdata == '1);
        if (op[1]) special_res = div_zero ? rs1_rdata : '0;
        else       special_res = div_zero ? '1 : rs1_rdata;
    end

    // One iteration: multiply shifts the product right, divide shifts a quotient bit in.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, a_q} & {(XLEN+1){b_q[0]}});
        rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        trial    = rem_sh - {1'b0, b_q};
        rem_new  = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        if (op_q[2]) step_acc = {rem_new, acc_q[XLEN-2:0], ~trial[XLEN]};
        else         step_acc = {mul_sum, acc_q[XLEN-1:1]};
        prod_s = neg_q ? -step_acc : step_acc;
        case (op_q)
            OP_MUL:                     final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:
                final_res = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
            default:
                final_res = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        endcase
    end

    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        neg_d   = neg_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    op_d  = op;
                    rd_d  = rd_waddr;
                    neg_d = (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
                    a_d   = abs_a;
                    b_d   = abs_b;
                    acc_d = '0;
                    cnt_d = '0;
                    if (div_zero || div_ovf) begin
                        state_d = S_DONE;
                        waddr_d = rd_waddr;
                        wdata_d = special_res;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    acc_d = step_acc;
                    a_d   = op_q[2] ? (a_q << 1) : a_q;
                    b_d   = op_q[2] ? b_q : (b_q >> 1);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                        waddr_d = rd_q;
                        wdata_d = final_res;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign hold_o     = ((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC);
    assign rd_we_o    = (state_q == S_DONE) && !flush;
    assign rd_waddr_o = waddr_q;
    assign rd_wdata_o = wdata_q;

endmodule
